dac_spi_tx: RTL and testbench

- Downstream stage of the digital signal processor: consumes its 16-bit valid/data sample stream and drives an external SPI DAC.
- Buffers samples in a small FIFO.
- Launches exactly one SPI frame per sample period from an internal sample-rate counter.
- On FIFO underrun, re-sends the last sample and flags the event.

---
 rtl/dac_spi_tx.sv | 160 ++++++++++++++++
 tb/tb_dac_spi_tx.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_tx.sv
// Sample FIFO feeding a mode-0 SPI DAC transmitter; one frame is launched per sample period.
// On an empty FIFO at launch time the previous sample is re-sent and underrun pulses.
module dac_spi_tx #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned SAMPLE_PERIOD = 1024
) (
  input  logic                        axis_aclk,
  input  logic                        axis_aresetn,
  input  logic                        s_axis_valid,
  input  logic [DATA_WIDTH-1:0]       s_axis_data,
  output logic                        s_axis_ready,
  output logic                        dac_cs_n,
  output logic                        dac_sclk,
  output logic                        dac_mosi,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underrun,
  output logic                        tick_missed
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW  = PtrW + 1;
  localparam int unsigned CntW  = $clog2(SAMPLE_PERIOD);
  localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HalfW = $clog2(2 * DATA_WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LvlW-1:0]       level_q, level_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DivW-1:0]       div_q, div_d;
  logic [HalfW-1:0]      half_q, half_d;
  logic                  missed_q, missed_d;
  logic                  run_q;

  logic                  tick, idle, fifo_empty, fifo_full, push, pop, div_last, half_last;
  logic [DATA_WIDTH-1:0] head;

  assign tick       = (cnt_q == CntW'(SAMPLE_PERIOD - 1));
  assign idle       = (state_q == StIdle);
  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LvlW'(FIFO_DEPTH));
  assign push       = s_axis_valid & s_axis_ready;
  assign pop        = tick & idle & ~fifo_empty;
  assign head       = mem_q[rptr_q];
  assign div_last   = (div_q == DivW'(CLK_DIV - 1));
  assign half_last  = (half_q == HalfW'(2 * DATA_WIDTH - 1));

  // run_q keeps ready low while in reset even though the FIFO is empty.
  assign s_axis_ready = run_q & ~fifo_full;
  assign fifo_level   = level_q;
  assign underrun     = tick & idle & fifo_empty;
  assign tick_missed  = missed_q;

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (tick) state_d = StShift;
      StShift: if (div_last && half_last) state_d = StHold;
      StHold:  if (div_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dac_cs_n = 1'b1;
    dac_sclk = 1'b0;
    dac_mosi = 1'b0;
    unique case (state_q)
      StShift: begin
        dac_cs_n = 1'b0;
        dac_sclk = half_q[0];
        dac_mosi = shreg_q[DATA_WIDTH-1];
      end
      StHold: begin
        dac_cs_n = 1'b0;
        dac_mosi = shreg_q[DATA_WIDTH-1];
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    wptr_d   = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d   = pop ? rptr_q + 1'b1 : rptr_q;
    level_d  = level_q + LvlW'(push) - LvlW'(pop);
    last_d   = pop ? head : last_q;
    missed_d = missed_q | (tick & ~idle);
    shreg_d  = shreg_q;
    div_d    = div_q;
    half_d   = half_q;
    unique case (state_q)
      StIdle: begin
        div_d  = '0;
        half_d = '0;
        if (tick) shreg_d = fifo_empty ? last_q : head;
      end
      StShift: begin
        if (div_last) begin
          div_d = '0;
          if (!half_last) begin
            half_d = half_q + 1'b1;
            // Odd half-periods end on a falling SCLK edge: advance to the next bit.
            if (half_q[0]) shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StHold:  div_d = div_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      cnt_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      last_q   <= '0;
      shreg_q  <= '0;
      div_q    <= '0;
      half_q   <= '0;
      missed_q <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      last_q   <= last_d;
      shreg_q  <= shreg_d;
      div_q    <= div_d;
      half_q   <= half_d;
      missed_q <= missed_d;
      run_q    <= 1'b1;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (push) mem_q[wptr_q] <= s_axis_data;
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Scoreboard bench for dac_spi_tx: expected frames queued at push time, compared as the
// SPI monitor captures them. A second instance with a short period exercises tick_missed.
module tb_dac_spi_tx;

  localparam int SP = 1024;

  typedef struct {
    logic [15:0] data;
    int          rises;
    int          low;
    int          start;
  } frame_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] data = '0;
  logic        ready, cs_n, sclk, mosi, under, tmiss;
  logic [2:0]  level;
  logic        ready2, cs2, sclk2, mosi2, under2, tm2;
  logic [2:0]  level2;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  int idle_bad = 0;

  logic [15:0] exq[$];
  frame_t      rxq[$];
  int          uq[$];

  dac_spi_tx u_dut (
    .axis_aclk(clk), .axis_aresetn(rstn), .s_axis_valid(valid), .s_axis_data(data),
    .s_axis_ready(ready), .dac_cs_n(cs_n), .dac_sclk(sclk), .dac_mosi(mosi),
    .fifo_level(level), .underrun(under), .tick_missed(tmiss)
  );

  dac_spi_tx #(.SAMPLE_PERIOD(40), .CLK_DIV(2)) u_dut2 (
    .axis_aclk(clk), .axis_aresetn(rstn), .s_axis_valid(1'b0), .s_axis_data(16'h0000),
    .s_axis_ready(ready2), .dac_cs_n(cs2), .dac_sclk(sclk2), .dac_mosi(mosi2),
    .fifo_level(level2), .underrun(under2), .tick_missed(tm2)
  );

  always #5 clk = ~clk;

  // Cycle index aligned with the sample-period counter: 0 in reset, tick at SP-1.
  always @(posedge clk) cyc <= rstn ? cyc + 1 : 0;

  logic        mon_in = 1'b0, mon_prev = 1'b0;
  logic [15:0] mon_sh;
  int          mon_rises, mon_low, mon_start;

  always @(negedge clk) begin
    if (!rstn) begin
      mon_in   = 1'b0;
      mon_prev = 1'b0;
    end else begin
      if (under) uq.push_back(cyc);
      if (!cs_n) begin
        if (!mon_in) begin
          mon_in = 1'b1; mon_rises = 0; mon_low = 0; mon_start = cyc; mon_sh = '0;
        end
        mon_low++;
        if (sclk && !mon_prev) begin
          mon_sh = {mon_sh[14:0], mosi};
          mon_rises++;
        end
      end else begin
        if (mon_in) begin
          rxq.push_back('{mon_sh, mon_rises, mon_low, mon_start});
          mon_in = 1'b0;
        end
        if (sclk || mosi) idle_bad++;
      end
      mon_prev = sclk;
    end
  end

  task automatic wait_phase(input int p);
    do @(negedge clk); while ((cyc % SP) != p);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait_rx(input int k, input int budget);
    int n = 0;
    while (rxq.size() < k && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Caller is at a negedge; the transfer happens on the next posedge with ready high.
  task automatic push_sample(input logic [15:0] d);
    int n = 0;
    valid = 1'b1;
    data  = d;
    while (!ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    valid = 1'b0;
    if (n >= 3000) begin
      vecs++; errs++;
      $display("FAIL push_timeout: ready stayed %b, required 1 for sample %h", ready, d);
    end else begin
      exq.push_back(d);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    vecs++;
    if ({cs_n, sclk, mosi, ready, under, tmiss, level} !== 9'b100000_000) begin
      errs++;
      $display("FAIL reset_outputs: got %b, required %b",
               {cs_n, sclk, mosi, ready, under, tmiss, level}, 9'b100000_000);
    end
    rstn = 1'b1;
    @(negedge clk);
    vecs++;
    if (ready !== 1'b1 || level !== 3'd0) begin
      errs++;
      $display("FAIL ready_after_reset: ready=%b level=%0d, required 1 and 0", ready, level);
    end
    uq.delete(); rxq.delete(); exq.delete();
  endtask

  task automatic test_tick_missed();
    wait_cyc(60);
    vecs++;
    if (tm2 !== 1'b0) begin
      errs++; $display("FAIL tick_missed_early: got %b, required 0", tm2);
    end
    wait_cyc(100);
    vecs++;
    if (tm2 !== 1'b1) begin
      errs++; $display("FAIL tick_missed_set: got %b, required 1", tm2);
    end
    wait_cyc(300);
    vecs++;
    if (tm2 !== 1'b1 || tmiss !== 1'b0) begin
      errs++; $display("FAIL tick_missed_sticky: short=%b long=%b, required 1 and 0", tm2, tmiss);
    end
  endtask

  task automatic test_underrun_idle();
    frame_t f;
    logic [15:0] w;
    repeat (3) exq.push_back(16'h0000);
    wait_rx(3, 3500);
    vecs++;
    if (uq.size() != 3) begin
      errs++; $display("FAIL idle_underrun_count: got %0d, required 3", uq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vecs++;
        if (uq[i] != SP - 1 + SP * i) begin
          errs++;
          $display("FAIL idle_underrun_cycle%0d: got %0d, required %0d", i, uq[i], SP - 1 + SP * i);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (rxq.size() == 0) begin
        errs++; $display("FAIL idle_frame%0d: no frame captured, required one", i);
      end else begin
        f = rxq.pop_front();
        w = exq.pop_front();
        if ({f.data, f.rises[7:0], f.low[7:0], f.start} !== {w, 8'd16, 8'd66, SP * (i + 1)}) begin
          errs++;
          $display("FAIL idle_frame%0d: data=%h rises=%0d low=%0d start=%0d, required %h 16 66 %0d",
                   i, f.data, f.rises, f.low, f.start, w, SP * (i + 1));
        end
      end
    end
    uq.delete();
  endtask

  task automatic test_single();
    frame_t f;
    wait_phase(100);
    push_sample(16'hA5C3);
    vecs++;
    if (level !== 3'd1) begin
      errs++; $display("FAIL single_level_push: got %0d, required 1", level);
    end
    wait_phase(SP - 1);
    @(negedge clk);
    vecs++;
    if (level !== 3'd0) begin
      errs++; $display("FAIL single_level_pop: got %0d, required 0", level);
    end
    wait_rx(1, 1200);
    vecs++;
    if (rxq.size() == 0 || uq.size() != 0) begin
      errs++;
      $display("FAIL single_frame: frames=%0d underruns=%0d, required 1 and 0", rxq.size(), uq.size());
    end else begin
      f = rxq.pop_front();
      if ({f.data, f.rises[7:0], f.low[7:0]} !== {exq.pop_front(), 8'd16, 8'd66}) begin
        errs++;
        $display("FAIL single_frame: data=%h rises=%0d low=%0d, required a5c3 16 66",
                 f.data, f.rises, f.low);
      end
    end
    exq.delete(); uq.delete();
  endtask

  task automatic test_back_to_back();
    frame_t f;
    logic [15:0] w;
    wait_phase(100);
    for (int i = 1; i <= 4; i++) push_sample(16'(i));
    vecs++;
    if (level !== 3'd4 || ready !== 1'b0) begin
      errs++; $display("FAIL b2b_full: level=%0d ready=%b, required 4 and 0", level, ready);
    end
    push_sample(16'h0005);
    vecs++;
    if ((cyc % SP) > 3) begin
      errs++; $display("FAIL b2b_holdoff: fifth accepted at phase %0d, required just after tick", cyc % SP);
    end
    wait_rx(5, 5 * 1100);
    for (int i = 0; i < 5; i++) begin
      vecs++;
      if (rxq.size() == 0 || exq.size() == 0) begin
        errs++; $display("FAIL b2b_frame%0d: no frame captured, required one", i);
      end else begin
        f = rxq.pop_front();
        w = exq.pop_front();
        if ({f.data, f.rises[7:0], f.low[7:0]} !== {w, 8'd16, 8'd66}) begin
          errs++;
          $display("FAIL b2b_frame%0d: data=%h rises=%0d low=%0d, required %h 16 66",
                   i, f.data, f.rises, f.low, w);
        end
      end
    end
    uq.delete();
  endtask

  task automatic test_repeat();
    frame_t f;
    logic [15:0] w;
    wait_phase(100);
    push_sample(16'h1234);
    exq.push_back(16'h1234);
    exq.push_back(16'h1234);
    wait_rx(3, 3 * 1100);
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (rxq.size() == 0) begin
        errs++; $display("FAIL repeat_frame%0d: no frame captured, required one", i);
      end else begin
        f = rxq.pop_front();
        w = exq.pop_front();
        if (f.data !== w || f.rises != 16) begin
          errs++;
          $display("FAIL repeat_frame%0d: data=%h rises=%0d, required %h 16", i, f.data, f.rises, w);
        end
      end
    end
    vecs++;
    if (uq.size() != 2 || (uq[0] % SP) != SP - 1 || (uq[1] - uq[0]) != SP) begin
      errs++; $display("FAIL repeat_underruns: got %0d pulses, required 2 one period apart", uq.size());
    end
    exq.delete(); uq.delete();
  endtask

  task automatic test_full_tick();
    frame_t f;
    logic [15:0] w;
    wait_phase(100);
    for (int i = 0; i < 4; i++) push_sample(16'h0011 + 16'(i));
    wait_phase(SP - 1);
    vecs++;
    if (level !== 3'd4 || ready !== 1'b0) begin
      errs++; $display("FAIL full_tick_before: level=%0d ready=%b, required 4 and 0", level, ready);
    end
    valid = 1'b1;
    data  = 16'h0099;
    @(negedge clk);
    valid = 1'b0;
    vecs++;
    if (level !== 3'd3) begin
      errs++; $display("FAIL full_tick_refused: level=%0d, required 3", level);
    end
    wait_rx(4, 4 * 1100);
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (rxq.size() == 0 || exq.size() == 0) begin
        errs++; $display("FAIL full_frame%0d: no frame captured, required one", i);
      end else begin
        f = rxq.pop_front();
        w = exq.pop_front();
        if (f.data !== w) begin
          errs++; $display("FAIL full_frame%0d: data=%h, required %h", i, f.data, w);
        end
      end
    end
    uq.delete();
  endtask

  task automatic test_reset_midframe();
    frame_t f;
    int n = 0;
    wait_phase(100);
    push_sample(16'hFFFF);
    while (cs_n !== 1'b0 && n < 1200) begin
      @(negedge clk);
      n++;
    end
    repeat (29) @(negedge clk);
    vecs++;
    if (cs_n !== 1'b0 || mosi !== 1'b1) begin
      errs++; $display("FAIL midframe_bit7: cs_n=%b mosi=%b, required 0 and 1", cs_n, mosi);
    end
    rstn = 1'b0;
    @(negedge clk);
    vecs++;
    if ({cs_n, sclk, mosi, ready, level} !== 7'b1000_000) begin
      errs++;
      $display("FAIL midframe_reset: cs_n=%b sclk=%b mosi=%b ready=%b level=%0d, required 1 0 0 0 0",
               cs_n, sclk, mosi, ready, level);
    end
    @(negedge clk);
    rstn = 1'b1;
    exq.delete(); rxq.delete(); uq.delete();
    exq.push_back(16'h0000);
    wait_rx(1, 1200);
    vecs++;
    if (rxq.size() == 0 || uq.size() != 1) begin
      errs++;
      $display("FAIL post_reset_frame: frames=%0d underruns=%0d, required 1 and 1", rxq.size(), uq.size());
    end else begin
      f = rxq.pop_front();
      if ({f.data, f.low[7:0], f.start, uq[0]} !== {exq.pop_front(), 8'd66, SP, SP - 1}) begin
        errs++;
        $display("FAIL post_reset_frame: data=%h low=%0d start=%0d underrun=%0d, required 0000 66 %0d %0d",
                 f.data, f.low, f.start, uq[0], SP, SP - 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tick_missed();
    test_underrun_idle();
    test_single();
    test_back_to_back();
    test_repeat();
    test_full_tick();
    test_reset_midframe();
    vecs++;
    if (idle_bad != 0) begin
      errs++; $display("FAIL idle_toggle: %0d cycles with sclk/mosi active, required 0", idle_bad);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
